// File: rtl/pb_port_responder.sv
// PicoBlaze I/O-bus responder: byte FIFO from the fabric, status/command ports,
// periodic tick and a request/service/EOI interrupt handshake.
module pb_port_responder #(
   parameter int          CLK_FREQ_HZ = 25000000,
   parameter int          TICK_HZ     = 1,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [7:0]  BASE_ADDR   = 8'h00
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int TW  = $clog2(DIV);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] tick_cnt;
   logic [1:0]    en;
   logic          overflow, tick_pending, in_service;
   irq_state_t    state;

   logic       sel, empty, full, push, pop, wr_en, wr_cmd, tick_set;
   logic       cond, eoi_cond, tick_after;
   logic [7:0] head, status, rd_data;

   assign sel      = (port_id[7:2] == BASE_ADDR[7:2]);
   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign push     = data_in_valid & ~full;
   assign pop      = read_strobe & sel & (port_id[1:0] == 2'd0) & ~empty;
   assign wr_en    = write_strobe & sel & (port_id[1:0] == 2'd2);
   assign wr_cmd   = write_strobe & sel & (port_id[1:0] == 2'd3);
   assign tick_set = (tick_cnt == TW'(DIV - 1));
   assign head     = empty ? 8'h00 : mem[rd_ptr];
   assign status   = {in_service, 3'b000, overflow, tick_pending, full, ~empty};
   assign data_in_ready = ~full;

   assign cond       = (en[0] & ~empty) | (en[1] & tick_pending);
   // Condition as it will stand after an EOI write that may also clear tick_pending.
   assign tick_after = tick_set | (tick_pending & ~out_port[1]);
   assign eoi_cond   = (en[0] & ~empty) | (en[1] & tick_after);

   always_comb begin
      rd_data = 8'h00;
      if (sel) begin
         case (port_id[1:0])
            2'd0:    rd_data = head;
            2'd1:    rd_data = status;
            2'd2:    rd_data = 8'(count);
            default: rd_data = 8'h00;
         endcase
      end
   end

   // NOTE: storage array has no reset; only pointers/count define its contents,
   // which keeps it mappable to RAM and discards data on reset by construction.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   // NOTE: all sequential state uses non-blocking assignments so every branch
   // below reads the pre-edge values of the other registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         tick_cnt     <= '0;
         tick_pending <= 1'b0;
         en           <= 2'b00;
         in_port      <= 8'h00;
      end else begin
         in_port <= rd_data;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;

         if (data_in_valid && full)      overflow <= 1'b1;
         else if (wr_cmd && out_port[0]) overflow <= 1'b0;

         if (tick_set) begin
            tick_cnt     <= '0;
            tick_pending <= 1'b1;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (wr_cmd && out_port[1]) tick_pending <= 1'b0;
         end

         if (wr_en) en <= out_port[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         interrupt  <= 1'b0;
         in_service <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cond) begin
                  state     <= REQ;
                  interrupt <= 1'b1;
               end
            end
            REQ: begin
               if (en == 2'b00) begin
                  state     <= IDLE;
                  interrupt <= 1'b0;
               end else if (interrupt_ack) begin
                  state      <= SERVICE;
                  interrupt  <= 1'b0;
                  in_service <= 1'b1;
               end
            end
            SERVICE: begin
               if (wr_cmd && out_port[7]) begin
                  in_service <= 1'b0;
                  // Re-raise immediately when work is still outstanding.
                  if (eoi_cond) begin
                     state     <= REQ;
                     interrupt <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               interrupt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pb_port_responder.sv
// Directed bench: instance a (slow tick) covers FIFO/ports/interrupt,
// instance b (tick every 10 cycles) covers the tick-driven interrupt.
module tb_pb_port_responder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] port_id = 8'h00, out_port = 8'h00, data_in = 8'h00;
   logic       write_strobe = 1'b0, read_strobe = 1'b0;
   logic       interrupt_ack = 1'b0, data_in_valid = 1'b0;
   logic [7:0] in_port_a, in_port_b;
   logic       interrupt_a, interrupt_b, ready_a, ready_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pb_port_responder #(.CLK_FREQ_HZ(1000), .TICK_HZ(1), .FIFO_DEPTH(8), .BASE_ADDR(8'h00)) dut_a (
      .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port_a),
      .interrupt(interrupt_a), .interrupt_ack(interrupt_ack), .data_in(data_in),
      .data_in_valid(data_in_valid), .data_in_ready(ready_a));

   pb_port_responder #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .FIFO_DEPTH(8), .BASE_ADDR(8'h00)) dut_b (
      .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port_b),
      .interrupt(interrupt_b), .interrupt_ack(interrupt_ack), .data_in(data_in),
      .data_in_valid(data_in_valid), .data_in_ready(ready_b));

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      port_id = 8'h00; out_port = 8'h00; data_in = 8'h00;
      write_strobe = 1'b0; read_strobe = 1'b0;
      interrupt_ack = 1'b0; data_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic push(input logic [7:0] b);
      data_in = b; data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
   endtask

   task automatic wr(input logic [1:0] off, input logic [7:0] d);
      port_id = {6'b0, off}; out_port = d; write_strobe = 1'b1;
      step();
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [1:0] off, output logic [7:0] d);
      port_id = {6'b0, off}; read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      d = in_port_a;
   endtask

   logic [7:0] v;
   logic [7:0] exp_fifo [5];

   initial begin
      // Reset state and basic FIFO order
      do_reset();
      check("rst_in_port", in_port_a, 8'h00);
      check("rst_interrupt", {7'b0, interrupt_a}, 8'h00);
      check("rst_ready", {7'b0, ready_a}, 8'h01);
      push(8'h11); push(8'h22); push(8'h33);
      rd(2'd1, v); check("t1_status", v, 8'h01);
      rd(2'd2, v); check("t1_count", v, 8'h03);
      rd(2'd0, v); check("t1_pop0", v, 8'h11);
      rd(2'd0, v); check("t1_pop1", v, 8'h22);
      rd(2'd0, v); check("t1_pop2", v, 8'h33);
      rd(2'd1, v); check("t1_status_end", v, 8'h00);

      // Fill to full, overflow, clear overflow
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
      check("t2_ready_full", {7'b0, ready_a}, 8'h00);
      push(8'hFF);
      rd(2'd1, v); check("t2_status_ovf", v, 8'h0B);
      rd(2'd2, v); check("t2_count_full", v, 8'h08);
      wr(2'd3, 8'h01);
      rd(2'd1, v); check("t2_status_clr", v, 8'h03);
      rd(2'd0, v); check("t2_head", v, 8'hA0);

      // Tick-driven interrupt on instance b (tick at 10th edge after reset)
      do_reset();
      wr(2'd2, 8'h02);
      port_id = 8'h01;
      repeat (8) step();
      check("t3_int_before", {7'b0, interrupt_b}, 8'h00);
      step();
      check("t3_int_tick_edge", {7'b0, interrupt_b}, 8'h00);
      step();
      check("t3_int_raised", {7'b0, interrupt_b}, 8'h01);
      check("t3_status_pend", in_port_b, 8'h04);
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
      check("t3_int_acked", {7'b0, interrupt_b}, 8'h00);
      step();
      check("t3_status_svc", in_port_b, 8'h84);
      wr(2'd3, 8'h82);
      port_id = 8'h01;
      step();
      check("t3_status_eoi", in_port_b, 8'h00);
      check("t3_no_reassert", {7'b0, interrupt_b}, 8'h00);
      step();
      check("t3_no_reassert2", {7'b0, interrupt_b}, 8'h00);

      // Data-driven interrupt, EOI without popping re-raises
      do_reset();
      wr(2'd2, 8'h01);
      push(8'h55);
      check("t4_int_low_yet", {7'b0, interrupt_a}, 8'h00);
      step();
      check("t4_int_raised", {7'b0, interrupt_a}, 8'h01);
      interrupt_ack = 1'b1;
      step();
      check("t4_int_acked", {7'b0, interrupt_a}, 8'h00);
      step();
      interrupt_ack = 1'b0;
      check("t4_ack_in_service", {7'b0, interrupt_a}, 8'h00);
      rd(2'd1, v); check("t4_status_svc", v, 8'h81);
      wr(2'd3, 8'h80);
      check("t4_reassert", {7'b0, interrupt_a}, 8'h01);
      wr(2'd2, 8'h00);
      step();
      check("t4_disable_drop", {7'b0, interrupt_a}, 8'h00);

      // Simultaneous push/pop at count 4, then pop on empty
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_fifo[i] = 8'(i + 1);
         push(exp_fifo[i]);
      end
      exp_fifo[4] = 8'h05;
      data_in = exp_fifo[4]; data_in_valid = 1'b1;
      port_id = 8'h00; read_strobe = 1'b1;
      step();
      data_in_valid = 1'b0; read_strobe = 1'b0;
      check("t5_simul_head", in_port_a, exp_fifo[0]);
      rd(2'd2, v); check("t5_count_kept", v, 8'h04);
      for (int i = 1; i < 5; i++) begin
         rd(2'd0, v); check($sformatf("t5_order%0d", i), v, exp_fifo[i]);
      end
      rd(2'd0, v); check("t5_pop_empty", v, 8'h00);
      rd(2'd2, v); check("t5_count_zero", v, 8'h00);

      // Asynchronous reset mid-operation
      wr(2'd2, 8'h01);
      push(8'h77); push(8'h78);
      port_id = 8'h01;
      step();
      check("t6_int_pre", {7'b0, interrupt_a}, 8'h01);
      check("t6_status_pre", in_port_a, 8'h01);
      data_in = 8'h79; data_in_valid = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_int_async", {7'b0, interrupt_a}, 8'h00);
      check("t6_in_port_async", in_port_a, 8'h00);
      check("t6_ready_async", {7'b0, ready_a}, 8'h01);
      data_in_valid = 1'b0;
      step();
      reset_n = 1'b1;
      rd(2'd1, v); check("t6_status_after", v, 8'h00);
      rd(2'd2, v); check("t6_count_after", v, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
